// File: rtl/square_sequencer.sv
// Square sequencer: walks one lit square around a 4-digit 7-seg loop.
// Ports: clk_i, rst_ni, en_i, cw_i, step_i -> in0_o..in3_o, pos_o, tick_o
module square_sequencer #(
  parameter int unsigned N             = 24,
  parameter logic [6:0]  TOP_SQUARE    = 7'b0011100,
  parameter logic [6:0]  BOTTOM_SQUARE = 7'b1100010,
  parameter logic [6:0]  BLANK         = 7'b1111111
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       cw_i,
  input  logic       step_i,
  output logic [6:0] in0_o,
  output logic [6:0] in1_o,
  output logic [6:0] in2_o,
  output logic [6:0] in3_o,
  output logic [2:0] pos_o,
  output logic       tick_o
);

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  logic [N-1:0] cnt_q;
  logic [2:0]   pos_q;
  logic         step_q;
  logic         tick_q;

  logic         wrap;
  logic         step_edge;
  logic         adv;

  // Manual steps only count while free-run is off, so the two
  // sources are mutually exclusive and at most one advance occurs.
  assign wrap      = en_i && (cnt_q == CNT_MAX);
  assign step_edge = !en_i && step_i && !step_q;
  assign adv       = wrap || step_edge;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pos_q  <= 3'd0;
      step_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      // Clearing while disabled guarantees a full period on restart.
      cnt_q  <= en_i ? (cnt_q + CNT_ONE) : '0;
      step_q <= step_i;
      tick_q <= adv;
      if (adv) begin
        pos_q <= cw_i ? (pos_q + 3'd1) : (pos_q - 3'd1);
      end
    end
  end

  // Top row runs digit 3 -> 0, bottom row returns digit 0 -> 3.
  always_comb begin
    in0_o = BLANK;
    in1_o = BLANK;
    in2_o = BLANK;
    in3_o = BLANK;
    unique case (pos_q)
      3'd0: in3_o = TOP_SQUARE;
      3'd1: in2_o = TOP_SQUARE;
      3'd2: in1_o = TOP_SQUARE;
      3'd3: in0_o = TOP_SQUARE;
      3'd4: in0_o = BOTTOM_SQUARE;
      3'd5: in1_o = BOTTOM_SQUARE;
      3'd6: in2_o = BOTTOM_SQUARE;
      3'd7: in3_o = BOTTOM_SQUARE;
      default: in3_o = TOP_SQUARE;
    endcase
  end

  assign pos_o  = pos_q;
  assign tick_o = tick_q;

endmodule

// File: doc/square_sequencer.md
SQUARE_SEQUENCER -- requirements
Module: square_sequencer

Interface
REQ-001 SHALL provide parameter N, default 24, meaning prescaler counter width; step period = 2^N clk_i cycles.
REQ-002 SHALL provide parameter TOP_SQUARE, default 7'b0011100, meaning segment pattern of the upper square (segments A,B,F,G lit).
REQ-003 SHALL provide parameter BOTTOM_SQUARE, default 7'b1100010, meaning segment pattern of the lower square (segments C,D,E,G lit).
REQ-004 SHALL provide parameter BLANK, default 7'b1111111, meaning segment pattern of an unlit digit.
REQ-005 SHALL provide port clk_i, input, 1, meaning the single clock; all state is on its rising edge.
REQ-006 SHALL provide port rst_ni, input, 1, meaning the asynchronous, active-low reset.
REQ-007 SHALL provide port en_i, input, 1, meaning free-run enable for automatic stepping.
REQ-008 SHALL provide port cw_i, input, 1, meaning direction: 1 = clockwise, 0 = counter-clockwise.
REQ-009 SHALL provide port step_i, input, 1, meaning manual single-step request, honoured only while en_i=0.
REQ-010 SHALL provide ports in0_o, in1_o, in2_o, in3_o, output, 7 each, meaning per-digit segment patterns for the time multiplexer; digit 3 is leftmost.
REQ-011 SHALL provide port pos_o, output, 3, meaning current square position 0..7.
REQ-012 SHALL provide port tick_o, output, 1, meaning one-cycle pulse marking each position change.

Function
REQ-013 Position map SHALL be: pos 0..3 = TOP_SQUARE on digit (3-pos); pos 4..7 = BOTTOM_SQUARE on digit (pos-4); all other digits = BLANK.
REQ-014 This map SHALL trace a closed loop: across the top from digit 3 to digit 0, then back along the bottom from digit 0 to digit 3.
REQ-015 in0_o..in3_o SHALL be a combinational decode of the pos register, so they change in the same cycle as pos_o.
REQ-016 Exactly one digit SHALL be non-BLANK at all times.
REQ-017 Prescaler cnt (N bits) SHALL increment once per cycle while en_i=1.
REQ-018 cnt SHALL be cleared to 0 on any cycle sampled with en_i=0, so a restart always yields a full period.
REQ-019 When en_i=1 and cnt=2^N-1, the next edge SHALL wrap cnt to 0 and advance pos.
REQ-020 With en_i held at 1 from cnt=0, the first advance SHALL occur 2^N cycles later, and every advance after that at 2^N-cycle intervals.
REQ-021 Clockwise advance SHALL be pos <= (pos+1) mod 8; counter-clockwise advance SHALL be pos <= (pos-1) mod 8.
REQ-022 The mod-8 rule SHALL wrap 7->0 and 0->7.
REQ-023 cw_i SHALL be sampled only on the advancing edge; a direction change between advances produces no output change until the next advance.
REQ-024 step_i SHALL be edge-detected with a registered copy (step_q).
REQ-025 A rising edge of step_i (step_i=1, step_q=0) while en_i=0 SHALL advance pos by one in direction cw_i on that edge.
REQ-026 step_i held high SHALL cause only one advance.
REQ-027 step_i edges while en_i=1 SHALL be ignored; step_q SHALL still track step_i.
REQ-028 If en_i deasserts on the same edge cnt would wrap, no advance SHALL occur, and cnt SHALL clear.
REQ-029 tick_o SHALL be registered and high for exactly the one cycle in which the new pos value is first visible.
REQ-030 tick_o SHALL be generated identically for automatic and manual advances.
REQ-031 No more than one advance SHALL occur per clock cycle.

Reset
REQ-032 While rst_ni=0, asynchronously and independent of clk_i: pos=0, cnt=0, step_q=0, tick_o=0.
REQ-033 In reset, outputs SHALL be in3_o=TOP_SQUARE and in2_o=in1_o=in0_o=BLANK.
REQ-034 Reset asserted mid-period SHALL discard the partial count.
REQ-035 After rst_ni rises, the first automatic advance SHALL require a full 2^N enabled cycles.

Verification (bench uses N=3, period 8)
REQ-036 Reset, then en_i=1, cw_i=1 for 64 cycles: pos_o steps 0,1,...,7,0 every 8 cycles; tick_o is high 8 cycles total; the lit digit/pattern matches REQ-013 at every pos.
REQ-037 Starting at pos 0, en_i=1, cw_i=0: first advance gives pos_o=7, in3_o=BOTTOM_SQUARE, others BLANK.
REQ-038 en_i=0, step_i held high 5 cycles, then low, then pulsed once more: exactly two advances and two tick_o pulses; pos 0->1->2.
REQ-039 en_i=1 with step_i pulsed at cnt=3: no extra advance; the next advance still occurs at cnt wrap.
REQ-040 Toggle cw_i at cnt=4 while at pos 2: pos holds at 2 until the wrap, then becomes 1.
REQ-041 Assert rst_ni=0 asynchronously at cnt=5, pos=6: pos_o=0, tick_o=0, in3_o=TOP_SQUARE immediately, without a clock edge; after release with en_i=1, the next advance occurs 8 cycles later.
